// File: rtl/tape_reader.sv
// tape_reader -- paper-tape reader front end for io_unit.
//
// The host loads 5-bit frame codes into an internal FIFO. The reader presents
// them to io_unit one at a time at a mechanical character rate. Each frame is
// held on the data lines while val is high. Val stays high for HOLD_CYCLES after
// io_unit takes the frame. Frames are separated by an idle gap of GAP_CYCLES.
//
// Ports
//   clk                in   clock, all logic on posedge
//   reset              in   synchronous, active-high; clears everything
//   host_valid_in      in   host offers a frame
//   host_data_in       in   5-bit frame code
//   host_ready_out     out  FIFO can accept (!full && !flush_in)
//   flush_in           in   pulse: discard all queued frames
//   input_rdy_from_io  in   io_unit waiting for a frame
//   input_val_to_io    out  frame valid (registered)
//   input_data_to_io   out  frame (registered, stable while val=1)
//   fifo_count_out     out  queued frames, head included until popped
//   reader_busy_out    out  reader not idle
//   frames_read_out    out  frames delivered since reset (wraps)
module tape_reader #(
    parameter int DEPTH       = 16,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   host_valid_in,
    input  logic [4:0]             host_data_in,
    output logic                   host_ready_out,
    input  logic                   flush_in,
    input  logic                   input_rdy_from_io,
    output logic                   input_val_to_io,
    output logic [4:0]             input_data_to_io,
    output logic [$clog2(DEPTH):0] fifo_count_out,
    output logic                   reader_busy_out,
    output logic [15:0]            frames_read_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      mem_q [DEPTH];
    logic [4:0]      mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            val_q, val_d;
    logic [4:0]      data_q, data_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [15:0]     frames_q, frames_d;
    // Set when a flush lands while the presented frame is in HOLD: the FIFO
    // has already been emptied, so the pop at HOLD exit must not happen.
    logic            head_gone_q, head_gone_d;

    logic full;
    logic push;
    logic pop;

    assign full           = (count_q == CW'(DEPTH));
    assign host_ready_out = !full && !flush_in;
    assign push           = host_valid_in && host_ready_out;

    assign input_val_to_io  = val_q;
    assign input_data_to_io = data_q;
    assign fifo_count_out   = count_q;
    assign reader_busy_out  = (state_q != S_IDLE);
    assign frames_read_out  = frames_q;

    // Reader FSM: next state, output registers, counters, pop request.
    always_comb begin
        state_d     = state_q;
        val_d       = val_q;
        data_d      = data_q;
        hold_d      = hold_q;
        gap_d       = gap_q;
        frames_d    = frames_q;
        head_gone_d = head_gone_q;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A flush this cycle empties the FIFO, so do not start on a
                // frame that is about to be discarded.
                if (count_q != '0 && !flush_in) begin
                    state_d     = S_PRESENT;
                    val_d       = 1'b1;
                    data_d      = mem_q[rd_ptr_q];
                    head_gone_d = 1'b0;
                end
            end
            S_PRESENT: begin
                if (flush_in) begin
                    state_d = S_IDLE;
                    val_d   = 1'b0;
                end else if (input_rdy_from_io) begin
                    // val_q is 1 throughout PRESENT, so rdy alone is the handshake.
                    state_d = S_HOLD;
                    hold_d  = HW'(HOLD_CYCLES);
                end
            end
            S_HOLD: begin
                if (flush_in) begin
                    head_gone_d = 1'b1;
                end
                if (hold_q == HW'(1)) begin
                    state_d  = S_GAP;
                    val_d    = 1'b0;
                    frames_d = frames_q + 16'd1;
                    gap_d    = GW'(GAP_CYCLES);
                    pop      = !head_gone_q && !flush_in;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                val_d   = 1'b0;
            end
        endcase
    end

    // FIFO storage and pointers. Flush wins over push and pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = host_data_in;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            val_q       <= 1'b0;
            data_q      <= '0;
            hold_q      <= '0;
            gap_q       <= '0;
            frames_q    <= '0;
            head_gone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            val_q       <= val_d;
            data_q      <= data_d;
            hold_q      <= hold_d;
            gap_q       <= gap_d;
            frames_q    <= frames_d;
            head_gone_q <= head_gone_d;
        end
    end

    // Frame storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_tape_reader.sv
module tb_tape_reader;

    localparam int DEPTH = 16;
    localparam int HOLD  = 2;
    localparam int GAP   = 8;

    logic        clk;
    logic        reset;
    logic        host_valid_in;
    logic [4:0]  host_data_in;
    logic        host_ready_out;
    logic        flush_in;
    logic        input_rdy_from_io;
    logic        input_val_to_io;
    logic [4:0]  input_data_to_io;
    logic [4:0]  fifo_count_out;
    logic        reader_busy_out;
    logic [15:0] frames_read_out;

    tape_reader #(
        .DEPTH      (DEPTH),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .host_valid_in    (host_valid_in),
        .host_data_in     (host_data_in),
        .host_ready_out   (host_ready_out),
        .flush_in         (flush_in),
        .input_rdy_from_io(input_rdy_from_io),
        .input_val_to_io  (input_val_to_io),
        .input_data_to_io (input_data_to_io),
        .fifo_count_out   (fifo_count_out),
        .reader_busy_out  (reader_busy_out),
        .frames_read_out  (frames_read_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    // Frames queue in host order; a frame leaves the queue when its val pulse
    // ends after a handshake. Timing rules are checked as pulse/gap lengths.
    logic [4:0]  mq [$];
    logic [4:0]  delivered [$];
    logic [15:0] m_frames;
    logic        prev_val, hs_seen, drop_cur, head_flushed, last_fall_delivered;
    logic [4:0]  prev_data;
    int          hold_cnt, low_run, wait_cnt;

    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            m_frames = '0;
            prev_val = 1'b0;
            prev_data = '0;
            hs_seen = 1'b0;
            drop_cur = 1'b0;
            head_flushed = 1'b0;
            last_fall_delivered = 1'b0;
            hold_cnt = 0;
            low_run = 0;
            wait_cnt = 0;
        end else begin
            if (input_val_to_io && !prev_val) begin
                chk("rise_with_frame_queued", int'(mq.size() > 0), 1);
                if (mq.size() > 0) chk("rise_data", input_data_to_io, mq[0]);
                delivered.push_back(input_data_to_io);
                if (last_fall_delivered) chk("gap_min", int'(low_run >= GAP + 1), 1);
                hs_seen = 1'b0;
                drop_cur = 1'b0;
                head_flushed = 1'b0;
                hold_cnt = 0;
            end else if (input_val_to_io && prev_val) begin
                chk("data_stable", input_data_to_io, prev_data);
                if (hs_seen) begin
                    hold_cnt++;
                    chk("hold_not_too_long", int'(hold_cnt <= HOLD), 1);
                end
            end else if (!input_val_to_io && prev_val) begin
                if (hs_seen) begin
                    chk("hold_len", hold_cnt, HOLD);
                    m_frames = m_frames + 16'd1;
                    if (!head_flushed && mq.size() > 0) void'(mq.pop_front());
                    last_fall_delivered = 1'b1;
                end else begin
                    chk("val_fell_only_on_flush", drop_cur, 1);
                    last_fall_delivered = 1'b0;
                end
                low_run = 1;
            end else begin
                low_run++;
            end

            if (!input_val_to_io && mq.size() > 0) wait_cnt++;
            else wait_cnt = 0;
            chk("start_latency", int'(wait_cnt <= GAP + 2), 1);

            chk("count", fifo_count_out, mq.size());
            chk("ready", host_ready_out, int'((mq.size() < DEPTH) && !flush_in));
            chk("frames", frames_read_out, m_frames);
            if (input_val_to_io) chk("busy_when_val", reader_busy_out, 1);

            // Inputs sampled at the coming edge.
            if (input_val_to_io && !hs_seen) begin
                if (flush_in) drop_cur = 1'b1;
                else if (input_rdy_from_io) begin
                    hs_seen = 1'b1;
                    hold_cnt = 0;
                end
            end
            if (flush_in) begin
                mq.delete();
                if (input_val_to_io) head_flushed = 1'b1;
            end else if (host_valid_in && mq.size() < DEPTH) begin
                mq.push_back(host_data_in);
            end
            prev_val = input_val_to_io;
            prev_data = input_data_to_io;
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       hv;
        logic [4:0] hd;
        logic       rdy;
        logic       fl;
        logic       e_val;
        logic [4:0] e_data;
        int         e_cnt;
        logic       e_busy;
        int         e_frames;
        logic       e_ready;
    } vec_t;

    vec_t vt [14];

    logic [4:0] three [3];
    logic [4:0] fill [16];
    logic [4:0] extra;
    logic       acc;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        host_valid_in = 1'b0;
        host_data_in = '0;
        flush_in = 1'b0;
        input_rdy_from_io = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_val", input_val_to_io, 0);
        chk("rst_data", input_data_to_io, 0);
        chk("rst_count", fifo_count_out, 0);
        chk("rst_frames", frames_read_out, 0);
        chk("rst_busy", reader_busy_out, 0);
        chk("rst_ready", host_ready_out, 1);

        // Single frame 10011, rdy held high: outputs after each edge.
        vt[0] = '{1'b1, 5'b10011, 1'b1, 1'b0, 1'b0, 5'd0,  1, 1'b0, 0, 1'b1};
        vt[1] = '{1'b0, 5'd0,     1'b1, 1'b0, 1'b1, 5'd19, 1, 1'b1, 0, 1'b1};
        vt[2] = vt[1];
        vt[3] = vt[1];
        vt[4] = '{1'b0, 5'd0,     1'b1, 1'b0, 1'b0, 5'd19, 0, 1'b1, 1, 1'b1};
        for (int i = 5; i < 13; i++) vt[i] = vt[4];
        vt[13] = '{1'b0, 5'd0,    1'b1, 1'b0, 1'b0, 5'd19, 0, 1'b0, 1, 1'b1};

        for (int i = 0; i < 14; i++) begin
            host_valid_in = vt[i].hv;
            host_data_in = vt[i].hd;
            input_rdy_from_io = vt[i].rdy;
            flush_in = vt[i].fl;
            step();
            chk($sformatf("vec%0d_val", i), input_val_to_io, vt[i].e_val);
            chk($sformatf("vec%0d_data", i), input_data_to_io, vt[i].e_data);
            chk($sformatf("vec%0d_count", i), fifo_count_out, vt[i].e_cnt);
            chk($sformatf("vec%0d_busy", i), reader_busy_out, vt[i].e_busy);
            chk($sformatf("vec%0d_frames", i), frames_read_out, vt[i].e_frames);
            chk($sformatf("vec%0d_ready", i), host_ready_out, vt[i].e_ready);
        end

        // Three back-to-back frames, order preserved.
        three[0] = 5'b00001;
        three[1] = 5'b11110;
        three[2] = 5'b01010;
        delivered.delete();
        input_rdy_from_io = 1'b1;
        for (int k = 0; k < 3; k++) begin
            host_valid_in = 1'b1;
            host_data_in = three[k];
            step();
        end
        host_valid_in = 1'b0;
        for (int c = 0; c < 200 && !(frames_read_out == 16'd4 && !reader_busy_out); c++) step();
        chk("three_frames", frames_read_out, 4);
        chk("three_delivered", delivered.size(), 3);
        for (int k = 0; k < 3 && k < delivered.size(); k++)
            chk($sformatf("three_order%0d", k), delivered[k], three[k]);

        // Fill to DEPTH with rdy low; 17th push refused until one delivery.
        delivered.delete();
        input_rdy_from_io = 1'b0;
        for (int k = 0; k < 16; k++) begin
            fill[k] = 5'($urandom);
            host_valid_in = 1'b1;
            host_data_in = fill[k];
            step();
        end
        host_valid_in = 1'b0;
        step();
        chk("full_count", fifo_count_out, 16);
        chk("full_ready", host_ready_out, 0);
        extra = 5'($urandom);
        host_valid_in = 1'b1;
        host_data_in = extra;
        repeat (3) step();
        chk("full_no_push", fifo_count_out, 16);
        for (int c = 0; c < 50; c++) begin
            step();
            chk("stall_val", input_val_to_io, 1);
            chk("stall_data", input_data_to_io, fill[0]);
        end
        input_rdy_from_io = 1'b1;
        acc = 1'b0;
        for (int c = 0; c < 50 && !acc; c++) begin
            acc = host_ready_out && host_valid_in;
            step();
        end
        host_valid_in = 1'b0;
        chk("extra_accepted", acc, 1);
        chk("extra_count", fifo_count_out, 16);
        for (int c = 0; c < 600 && !(fifo_count_out == 0 && !reader_busy_out); c++) step();
        chk("fill_frames", frames_read_out, 21);
        chk("fill_delivered", delivered.size(), 17);
        for (int k = 0; k < 16 && k < delivered.size(); k++)
            chk($sformatf("fill_order%0d", k), delivered[k], fill[k]);
        if (delivered.size() == 17) chk("fill_tail", delivered[16], extra);

        // Flush while PRESENT.
        input_rdy_from_io = 1'b0;
        host_valid_in = 1'b1;
        host_data_in = 5'h05;
        step();
        host_data_in = 5'h0A;
        step();
        host_valid_in = 1'b0;
        for (int c = 0; c < 10 && !input_val_to_io; c++) step();
        chk("flushp_val_up", input_val_to_io, 1);
        step();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        chk("flushp_val", input_val_to_io, 0);
        chk("flushp_count", fifo_count_out, 0);
        chk("flushp_frames", frames_read_out, 21);
        chk("flushp_busy", reader_busy_out, 0);
        repeat (GAP + 4) step();
        chk("flushp_stays_low", input_val_to_io, 0);

        // Flush while HOLD: frame still counted, queued frame discarded.
        host_valid_in = 1'b1;
        host_data_in = 5'h11;
        step();
        host_data_in = 5'h12;
        step();
        host_valid_in = 1'b0;
        for (int c = 0; c < 10 && !input_val_to_io; c++) step();
        chk("flushh_val_up", input_val_to_io, 1);
        input_rdy_from_io = 1'b1;
        step();
        flush_in = 1'b1;
        step();
        flush_in = 1'b0;
        chk("flushh_val_held", input_val_to_io, 1);
        chk("flushh_count", fifo_count_out, 0);
        step();
        chk("flushh_val_fall", input_val_to_io, 0);
        chk("flushh_frames", frames_read_out, 22);
        repeat (GAP + 4) step();
        chk("flushh_stays_low", input_val_to_io, 0);
        chk("flushh_idle", reader_busy_out, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            host_valid_in = ($urandom_range(0, 7) < ((c < 1000) ? 1 : 4));
            host_data_in = 5'($urandom);
            input_rdy_from_io = ($urandom_range(0, 9) < 7);
            flush_in = ($urandom_range(0, 63) == 0);
            step();
        end
        host_valid_in = 1'b0;
        flush_in = 1'b0;
        input_rdy_from_io = 1'b1;
        for (int c = 0; c < 400 && !(fifo_count_out == 0 && !reader_busy_out); c++) step();
        chk("rand_drained", fifo_count_out, 0);
        chk("rand_idle", reader_busy_out, 0);
        chk("rand_frames", frames_read_out, m_frames);

        // Reset in the middle of a frame.
        input_rdy_from_io = 1'b0;
        host_valid_in = 1'b1;
        host_data_in = 5'h07;
        step();
        host_valid_in = 1'b0;
        step();
        chk("midrst_val_up", input_val_to_io, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_val", input_val_to_io, 0);
        chk("midrst_count", fifo_count_out, 0);
        chk("midrst_frames", frames_read_out, 0);
        chk("midrst_busy", reader_busy_out, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
